// File: rtl/flow_ctrl_unit.sv
// Control-flow unit: branch/jump decode, registered ALU flags and wrong-path squash after taken transfers.
// Optional loop counter (LDLC/DBNZ on opcode 3'b101) is enabled by defining FLOW_LOOP_CNT_EN.
module flow_ctrl_unit #(
   parameter int unsigned INSTR_W      = 9,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned LOOP_W       = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               instr_valid,
   input  logic               stall,
   input  logic               flag_we,
   input  logic [DATA_W-1:0]  alu_out,
   input  logic               alu_carry,
   output logic               jump_en,
   output logic               branch_en,
   output logic               squash,
   output logic [3:0]         flags_q,
   output logic               busy,
   output logic [LOOP_W-1:0]  loop_cnt
);

   localparam int unsigned   CNT_W      = 4;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
   localparam bit            FLUSH_EN   = (FLUSH_CYCLES != 0);
   localparam logic [2:0]    OP_JMP     = 3'b111;
   localparam logic [2:0]    OP_BRC     = 3'b110;
   localparam logic [2:0]    OP_LOOP    = 3'b101;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         flags_d;
   logic [2:0]         opcode;
   logic               eff_c;
   logic               cond_true_c;
   logic               jmp_take_c;
   logic               brc_take_c;
   logic               dbnz_take_c;
   logic               take_c;
   logic               unused_instr_bits;

   assign opcode            = Instruction[INSTR_W-1 -: 3];
   assign unused_instr_bits = ^Instruction[INSTR_W-4:3];
   assign eff_c             = instr_valid & ~stall & ~Reset & (state_q == ST_RUN);

   // Condition codes are evaluated on the registered (pre-update) flags {C,N,E,Z}.
   always_comb begin
      cond_true_c = 1'b0;
      case (Instruction[2:0])
         3'd0:    cond_true_c =  flags_q[0];
         3'd1:    cond_true_c = ~flags_q[0];
         3'd2:    cond_true_c =  flags_q[1];
         3'd3:    cond_true_c = ~flags_q[1];
         3'd4:    cond_true_c =  flags_q[2];
         3'd5:    cond_true_c = ~flags_q[2];
         3'd6:    cond_true_c =  flags_q[3];
         default: cond_true_c = ~flags_q[3];
      endcase
   end

   assign jmp_take_c = eff_c & (opcode == OP_JMP);
   assign brc_take_c = eff_c & (opcode == OP_BRC) & cond_true_c;
   assign take_c     = jmp_take_c | brc_take_c | dbnz_take_c;

`ifdef FLOW_LOOP_CNT_EN
   logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;

   // DBNZ is taken when the decremented count is nonzero.
   assign dbnz_take_c = eff_c & (opcode == OP_LOOP) & Instruction[0]
                        & (loop_cnt_q != LOOP_W'(1));

   always_comb begin
      loop_cnt_d = loop_cnt_q;
      if (eff_c && (opcode == OP_LOOP)) begin
         if (Instruction[0]) loop_cnt_d = loop_cnt_q - LOOP_W'(1);
         else                loop_cnt_d = LOOP_W'(alu_out);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) loop_cnt_q <= '0;
      else       loop_cnt_q <= loop_cnt_d;
   end

   assign loop_cnt = loop_cnt_q;
`else
   assign dbnz_take_c = 1'b0;
   assign loop_cnt    = '0;
`endif

   always_comb begin
      flags_d = flags_q;
      if (eff_c && flag_we)
         flags_d = {alu_carry, alu_out[DATA_W-1], ~alu_out[0], (alu_out == '0)};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
      end
   end

   // Next state: a taken transfer arms the squash window; it drains one step per non-stalled cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!stall) begin
         case (state_q)
            ST_RUN: begin
               if (take_c && FLUSH_EN) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end
            ST_FLUSH: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      squash    = 1'b0;
      busy      = 1'b0;
      jump_en   = jmp_take_c;
      branch_en = brc_take_c | dbnz_take_c;
      if (state_q == ST_FLUSH) begin
         squash = 1'b1;
         busy   = 1'b1;
      end
   end

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Scoreboard bench for flow_ctrl_unit: two instances (1 and 3 squash cycles) against a behavioural model.
module tb_flow_ctrl_unit;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [8:0] Instruction = '0;
   logic       instr_valid = 1'b0;
   logic       stall = 1'b0;
   logic       flag_we = 1'b0;
   logic [7:0] alu_out = '0;
   logic       alu_carry = 1'b0;

   logic       j1, b1, s1, bz1, j3, b3, s3, bz3;
   logic [3:0] f1, f3;
   logic [7:0] lc1, lc3;

   always #5 Clk = ~Clk;

   flow_ctrl_unit #(.INSTR_W(9), .DATA_W(8), .FLUSH_CYCLES(1), .LOOP_W(8)) u_dut1 (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
      .stall(stall), .flag_we(flag_we), .alu_out(alu_out), .alu_carry(alu_carry),
      .jump_en(j1), .branch_en(b1), .squash(s1), .flags_q(f1), .busy(bz1), .loop_cnt(lc1));

   flow_ctrl_unit #(.INSTR_W(9), .DATA_W(8), .FLUSH_CYCLES(3), .LOOP_W(8)) u_dut3 (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .instr_valid(instr_valid),
      .stall(stall), .flag_we(flag_we), .alu_out(alu_out), .alu_carry(alu_carry),
      .jump_en(j3), .branch_en(b3), .squash(s3), .flags_q(f3), .busy(bz3), .loop_cnt(lc3));

   typedef struct packed {
      logic       j;
      logic       b;
      logic       sq;
      logic       bz;
      logic [3:0] fl;
      logic [7:0] lc;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t c;
   } pair_t;

   typedef struct {
      logic [3:0] fl;
      int         left;
      logic [7:0] lc;
   } mst_t;

   pair_t exp_q[$];
   int    total = 0;
   int    bad   = 0;
   mst_t  m1 = '{fl: 4'h0, left: 0, lc: 8'h00};
   mst_t  m3 = '{fl: 4'h0, left: 0, lc: 8'h00};

   function automatic logic cond_holds(input logic [3:0] fl, input logic [2:0] cc);
      logic z, e, n, c;
      z = fl[0]; e = fl[1]; n = fl[2]; c = fl[3];
      case (cc)
         3'd0: return z;
         3'd1: return !z;
         3'd2: return e;
         3'd3: return !e;
         3'd4: return n;
         3'd5: return !n;
         3'd6: return c;
         default: return !c;
      endcase
   endfunction

   // Reference: squash window is a count of remaining wrong-path cycles.
   function automatic void model(input mst_t s, input int fc, output obs_t o, output mst_t nx);
      bit         run, eff, tj, tb, tl;
      logic [2:0] op;
      logic [7:0] dec;
      run = (s.left == 0);
      eff = !Reset && instr_valid && !stall && run;
      op  = Instruction[8:6];
      dec = s.lc - 8'd1;
      tj  = eff && (op == 3'b111);
      tb  = eff && (op == 3'b110) && cond_holds(s.fl, Instruction[2:0]);
`ifdef FLOW_LOOP_CNT_EN
      tl  = eff && (op == 3'b101) && Instruction[0] && (dec != 8'd0);
`else
      tl  = 1'b0;
`endif
      o.j  = tj;
      o.b  = tb || tl;
      o.sq = !run;
      o.bz = !run;
      o.fl = s.fl;
      o.lc = s.lc;
      nx = s;
      if (Reset) begin
         nx.fl = 4'h0; nx.left = 0; nx.lc = 8'h00;
      end else if (!stall) begin
         if (!run) nx.left = s.left - 1;
         else begin
            if (eff && flag_we)
               nx.fl = {alu_carry, alu_out[7], !alu_out[0], alu_out == 8'h00};
`ifdef FLOW_LOOP_CNT_EN
            if (eff && (op == 3'b101)) nx.lc = Instruction[0] ? dec : alu_out;
`endif
            if ((tj || tb || tl) && fc > 0) nx.left = fc;
         end
      end
   endfunction

   task automatic cyc(input bit rst, input bit iv, input bit st, input bit fwe,
                      input logic [8:0] ins, input logic [7:0] alu, input bit c, input bit chk);
      obs_t  o1, o3;
      mst_t  n1, n3;
      pair_t p;
      @(posedge Clk);
      #1;
      Reset = rst; instr_valid = iv; stall = st; flag_we = fwe;
      Instruction = ins; alu_out = alu; alu_carry = c;
      model(m1, 1, o1, n1);
      model(m3, 3, o3, n3);
      if (chk) begin
         p.a = o1; p.c = o3;
         exp_q.push_back(p);
      end
      m1 = n1;
      m3 = n3;
   endtask

   task automatic check(input int fc, input obs_t got, input obs_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL outputs fc=%0d t=%0t got j=%b b=%b sq=%b bz=%b fl=%h lc=%h required j=%b b=%b sq=%b bz=%b fl=%h lc=%h",
                  fc, $time, got.j, got.b, got.sq, got.bz, got.fl, got.lc,
                  exp.j, exp.b, exp.sq, exp.bz, exp.fl, exp.lc);
      end
   endtask

   // Monitor: outputs are valid every cycle once inputs have settled.
   initial begin
      pair_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(1, {j1, b1, s1, bz1, f1, lc1}, e.a);
            check(3, {j3, b3, s3, bz3, f3, lc3}, e.c);
         end
      end
   end

   localparam logic [8:0] NOP  = 9'b000_000_000;
   localparam logic [8:0] JMP  = 9'b111_000_000;
   localparam logic [8:0] BRZ  = 9'b110_000_000;
   localparam logic [8:0] BRNZ = 9'b110_000_001;
   localparam logic [8:0] LDLC = 9'b101_000_000;
   localparam logic [8:0] DBNZ = 9'b101_000_001;

   initial begin
      logic [2:0] op;
      logic [7:0] alu;
      int         r;
      cyc(1, 0, 0, 0, NOP, 8'h00, 0, 0);
      cyc(1, 1, 0, 1, JMP, 8'h55, 1, 1);
      // flag then branch on Z, taken then not-taken
      cyc(0, 1, 0, 1, NOP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, BRZ, 8'h00, 0, 1);
      repeat (4) cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      cyc(0, 1, 0, 1, NOP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, BRNZ, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      // same-cycle flag update with branch
      cyc(0, 1, 0, 1, NOP, 8'h01, 0, 1);
      cyc(0, 1, 0, 1, BRZ, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      // jump followed by jumps inside the squash window, with a stall inside
      cyc(0, 1, 0, 0, JMP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, JMP, 8'h00, 0, 1);
      cyc(0, 1, 1, 0, JMP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, JMP, 8'h00, 0, 1);
      repeat (4) cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      // stalled jump then released
      cyc(0, 1, 1, 0, JMP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, JMP, 8'h00, 0, 1);
      repeat (4) cyc(0, 0, 0, 0, NOP, 8'h00, 0, 1);
      // loop counter sequence
      cyc(0, 1, 0, 0, LDLC, 8'h03, 0, 1);
      repeat (4) begin
         cyc(0, 1, 0, 0, DBNZ, 8'h00, 0, 1);
         repeat (4) cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      end
      // reset in the middle of a squash window
      cyc(0, 1, 0, 1, NOP, 8'hFF, 1, 1);
      cyc(0, 1, 0, 0, JMP, 8'h00, 0, 1);
      cyc(1, 1, 1, 0, NOP, 8'h00, 0, 1);
      cyc(0, 1, 0, 0, NOP, 8'h00, 0, 1);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         op = (r < 4) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(5, 7));
         r = $urandom_range(0, 3);
         alu = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : 8'($urandom);
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
             1'($urandom), {op, 3'($urandom), 3'($urandom)}, alu, 1'($urandom), 1);
      end
      @(negedge Clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
